// File: rtl/vga_timing_detector.sv
// vga_timing_detector
//   Measures the hsync/vsync timing of an incoming video source and reports
//   it once the same frame timing has been seen for LOCK_FRAMES frames in a row.
//
//   Parameters
//     LOCK_FRAMES    consecutive matching frames needed to lock (1..15)
//     HS_ACTIVE_LOW  1: hs is active low
//     VS_ACTIVE_LOW  1: vs is active low
//   Ports
//     CLOCK150       pixel clock (only clock)
//     RESET_N        asynchronous active-low reset
//     hs, vs         raw sync inputs (synchronised internally)
//     h_total        clocks per line of the last accepted frame
//     h_sync         hs-active clocks per line
//     v_total        lines per frame
//     v_sync         lines with vs active
//     x              clocks since the last hs leading edge (saturating)
//     y              lines since the last vs leading edge (saturating)
//     locked         timing has been stable for LOCK_FRAMES frames
//     frame_strobe   one-clock pulse per vs leading edge handled while locked
module vga_timing_detector #(
  parameter int unsigned LOCK_FRAMES   = 3,
  parameter bit          HS_ACTIVE_LOW = 1'b1,
  parameter bit          VS_ACTIVE_LOW = 1'b0
) (
  input  logic        CLOCK150,
  input  logic        RESET_N,
  input  logic        hs,
  input  logic        vs,
  output logic [11:0] h_total,
  output logic [11:0] h_sync,
  output logic [10:0] v_total,
  output logic [10:0] v_sync,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        locked,
  output logic        frame_strobe
);

  // The idle pin level equals the polarity flag (active-low idles high).
  localparam logic       HS_IDLE = HS_ACTIVE_LOW;
  localparam logic       VS_IDLE = VS_ACTIVE_LOW;
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  logic        hs_s1, hs_s2, hs_d;
  logic        vs_s1, vs_s2, vs_d;
  logic [1:0]  warm;
  logic        hs_act, vs_act, hs_edge, vs_edge, sync_ok;

  logic [11:0] hw_cnt, last_period, last_width, first_period;
  logic        first_valid, frame_bad;
  logic [10:0] vcnt;

  logic [11:0] period, cur_period, cur_width;
  logic [10:0] cur_vtot, cur_vsync;
  logic        cur_bad, match, lost;

  state_t      state;
  logic [11:0] ref_period, ref_width;
  logic [10:0] ref_vtot, ref_vsync;
  logic [3:0]  match_cnt, match_next;

  // Edges are qualified only once the edge-detect register holds a sampled
  // pin value, so the reset value of the chain can never look like an edge.
  assign sync_ok = (warm == 2'd3);
  assign hs_act  = hs_s2 ^ HS_ACTIVE_LOW;
  assign vs_act  = vs_s2 ^ VS_ACTIVE_LOW;
  assign hs_edge = sync_ok & hs_act & ~(hs_d ^ HS_ACTIVE_LOW);
  assign vs_edge = sync_ok & vs_act & ~(vs_d ^ VS_ACTIVE_LOW);

  // An hs edge on the same clock as the vs edge belongs to the ending frame,
  // so the frame tuple folds in the values that edge is about to capture.
  assign period     = x + 12'd1;
  assign cur_period = hs_edge ? period : last_period;
  assign cur_width  = hs_edge ? hw_cnt : last_width;
  assign cur_vtot   = y + 11'd1;
  assign cur_vsync  = vcnt + {10'd0, hs_edge & vs_act};
  assign cur_bad    = frame_bad | (hs_edge & first_valid & (period != first_period));
  assign match      = ~cur_bad & (cur_period == ref_period) & (cur_width == ref_width) &
                      (cur_vtot == ref_vtot) & (cur_vsync == ref_vsync);
  assign match_next = match_cnt + 4'd1;
  // A saturated counter that is not being restarted this clock means lost input.
  assign lost       = ((x == '1) & ~hs_edge) | ((y == '1) & ~vs_edge);

  always_ff @(posedge CLOCK150 or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_s1 <= HS_IDLE;
      hs_s2 <= HS_IDLE;
      hs_d  <= HS_IDLE;
      vs_s1 <= VS_IDLE;
      vs_s2 <= VS_IDLE;
      vs_d  <= VS_IDLE;
      warm  <= '0;
    end else begin
      hs_s1 <= hs;
      hs_s2 <= hs_s1;
      hs_d  <= hs_s2;
      vs_s1 <= vs;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  always_ff @(posedge CLOCK150 or negedge RESET_N) begin
    if (!RESET_N) begin
      x            <= '0;
      y            <= '0;
      hw_cnt       <= '0;
      last_period  <= '0;
      last_width   <= '0;
      vcnt         <= '0;
      first_period <= '0;
      first_valid  <= 1'b0;
      frame_bad    <= 1'b0;
    end else begin
      if (hs_edge) begin
        x           <= '0;
        hw_cnt      <= 12'd1;
        last_period <= period;
        last_width  <= hw_cnt;
      end else begin
        if (x != '1) x <= x + 12'd1;
        if (hs_act && hw_cnt != '1) hw_cnt <= hw_cnt + 12'd1;
      end

      if (vs_edge) begin
        y           <= '0;
        vcnt        <= '0;
        first_valid <= 1'b0;
        frame_bad   <= 1'b0;
      end else if (hs_edge) begin
        if (y != '1) y <= y + 11'd1;
        if (vs_act && vcnt != '1) vcnt <= vcnt + 11'd1;
        if (!first_valid) begin
          first_period <= period;
          first_valid  <= 1'b1;
        end else if (period != first_period) begin
          frame_bad <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK150 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= SEARCH;
      ref_period   <= '0;
      ref_width    <= '0;
      ref_vtot     <= '0;
      ref_vsync    <= '0;
      match_cnt    <= '0;
      h_total      <= '0;
      h_sync       <= '0;
      v_total      <= '0;
      v_sync       <= '0;
      locked       <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (lost) begin
        state  <= SEARCH;
        locked <= 1'b0;
      end else if (vs_edge) begin
        case (state)
          SEARCH: state <= MEASURE;
          MEASURE: begin
            ref_period <= cur_period;
            ref_width  <= cur_width;
            ref_vtot   <= cur_vtot;
            ref_vsync  <= cur_vsync;
            match_cnt  <= '0;
            state      <= VERIFY;
          end
          VERIFY: begin
            if (match) begin
              match_cnt <= match_next;
              if (match_next == LOCK_N) begin
                state        <= LOCKED;
                locked       <= 1'b1;
                frame_strobe <= 1'b1;
                h_total      <= cur_period;
                h_sync       <= cur_width;
                v_total      <= cur_vtot;
                v_sync       <= cur_vsync;
              end
            end else begin
              ref_period <= cur_period;
              ref_width  <= cur_width;
              ref_vtot   <= cur_vtot;
              ref_vsync  <= cur_vsync;
              match_cnt  <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              frame_strobe <= 1'b1;
              h_total      <= cur_period;
              h_sync       <= cur_width;
              v_total      <= cur_vtot;
              v_sync       <= cur_vsync;
            end else begin
              state      <= VERIFY;
              locked     <= 1'b0;
              ref_period <= cur_period;
              ref_width  <= cur_width;
              ref_vtot   <= cur_vtot;
              ref_vsync  <= cur_vsync;
              match_cnt  <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
